// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: alignment/range checks, little-endian lane extraction on loads,
// and a two-cycle read-modify-write for byte/half stores.
module load_store_unit #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              stall,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [31:0]       fault_addr
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic              resp_valid_q;
  logic [31:0]       resp_data_q;
  logic [4:0]        resp_rd_q;
  logic              fault_q;
  logic [1:0]        fault_code_q;
  logic [31:0]       fault_addr_q;

  logic              accept, is_word, is_half, misaligned, out_of_range;
  logic              req_fault, req_ok, is_load;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_ext, lane_mask, lane_data, merged;

  // Size 2'b11 decodes as a word access.
  assign is_word      = req_size[1];
  assign is_half      = (req_size == 2'b01);
  assign accept       = req_valid && (state_q == StIdle);
  assign misaligned   = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[31:ADDR_W+2];
  assign req_fault    = accept && (misaligned || out_of_range);
  assign req_ok       = accept && !misaligned && !out_of_range;
  assign is_load      = req_ok && !req_we;
  assign idx          = req_addr[ADDR_W+1:2];

  assign byte_lane = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{req_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rdata;
    if (!is_word) begin
      if (is_half) load_ext = {{16{req_signed & half_lane[15]}}, half_lane};
      else         load_ext = {{24{req_signed & byte_lane[7]}}, byte_lane};
    end
  end

  // Replicate the store data across all lanes and let the mask pick the target lane(s).
  assign lane_mask = is_half ? (32'h0000_ffff << {req_addr[1], 4'b0000})
                             : (32'h0000_00ff << {req_addr[1:0], 3'b000});
  assign lane_data = is_half ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
  assign merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_ok) begin
          mem_addr = {{(32-ADDR_W){1'b0}}, idx};
          if (!req_we) begin
            mem_read = 1'b1;
          end else if (is_word) begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_read  = 1'b1;
            wr_idx_d  = idx;
            wr_data_d = merged;
            state_d   = StWrite;
          end
        end
      end
      StWrite: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {{(32-ADDR_W){1'b0}}, wr_idx_q};
        mem_wdata = wr_data_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      resp_valid_q <= is_load;
      if (is_load) begin
        resp_data_q <= load_ext;
        resp_rd_q   <= req_rd;
      end
      fault_q <= req_fault;
      if (req_fault) begin
        fault_code_q <= misaligned ? 2'b01 : 2'b10;
        fault_addr_q <= req_addr;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests plus hand-written
// sequences for reset-in-WRITE, reset-in-load and a back-to-back load/store stream.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, mem_write, mem_read, resp_valid, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_data, fault_addr;
  logic [4:0]  resp_rd;
  logic [1:0]  fault_code;
  logic        preload;

  logic [31:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_addr (fault_addr)
  );

  assign mem_rdata = mem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= i;
    end else if (mem_write) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_code;   // 00 = no fault
    logic [31:0] exp_wdata;  // merged word for sub-word stores
  } vec_t;

  function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                              logic [31:0] wdata, logic [4:0] rd, logic ev, logic [31:0] ed,
                              logic [1:0] code, logic [31:0] ew);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.exp_valid = ev; v.exp_data = ed; v.exp_code = code; v.exp_wdata = ew;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    logic subword, ok;
    int pulses, stalls;

    vecs[0]  = mk(0, 2'b10, 0, 32'h14, 0,            3,  1, 32'h0000_0005, 2'b00, 0);
    vecs[1]  = mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0,  0, 0,             2'b00, 0);
    vecs[2]  = mk(0, 2'b00, 1, 32'h0B, 0,            4,  1, 32'hFFFF_FFDE, 2'b00, 0);
    vecs[3]  = mk(0, 2'b01, 0, 32'h08, 0,            5,  1, 32'h0000_BEEF, 2'b00, 0);
    vecs[4]  = mk(0, 2'b01, 1, 32'h08, 0,            6,  1, 32'hFFFF_BEEF, 2'b00, 0);
    vecs[5]  = mk(0, 2'b00, 0, 32'h09, 0,            7,  1, 32'h0000_00BE, 2'b00, 0);
    vecs[6]  = mk(1, 2'b00, 0, 32'h11, 32'h123456AA, 0,  0, 0,             2'b00, 32'h0000_AA04);
    vecs[7]  = mk(0, 2'b10, 0, 32'h10, 0,            8,  1, 32'h0000_AA04, 2'b00, 0);
    vecs[8]  = mk(0, 2'b01, 0, 32'h03, 0,            1,  0, 0,             2'b01, 0);
    vecs[9]  = mk(0, 2'b10, 0, 32'h80, 0,            1,  0, 0,             2'b10, 0);
    vecs[10] = mk(1, 2'b10, 0, 32'h82, 32'h11111111, 0,  0, 0,             2'b01, 0);
    vecs[11] = mk(0, 2'b11, 0, 32'h14, 0,            9,  1, 32'h0000_0005, 2'b00, 0);
    vecs[12] = mk(1, 2'b01, 0, 32'h16, 32'hFFFF1234, 0,  0, 0,             2'b00, 32'h1234_0005);
    vecs[13] = mk(0, 2'b10, 0, 32'h14, 0,            0,  1, 32'h1234_0005, 2'b00, 0);
    vecs[14] = mk(0, 2'b01, 1, 32'h0A, 0,            10, 1, 32'hFFFF_DEAD, 2'b00, 0);
    vecs[15] = mk(1, 2'b00, 0, 32'h0B, 32'h00000080, 0,  0, 0,             2'b00, 32'h80AD_BEEF);
    vecs[16] = mk(0, 2'b00, 1, 32'h0B, 0,            11, 1, 32'hFFFF_FF80, 2'b00, 0);
    vecs[17] = mk(0, 2'b00, 0, 32'h7F, 0,            12, 1, 32'h0000_0000, 2'b00, 0);

    rst = 1'b1; preload = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", stall, 0);
    chk("reset mem_write", mem_write, 0);
    chk("reset mem_read", mem_read, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_data", resp_data, 0);
    chk("reset resp_rd", resp_rd, 0);
    chk("reset fault", fault, 0);
    chk("reset fault_code", fault_code, 0);
    chk("reset fault_addr", fault_addr, 0);
    @(negedge clk);
    rst = 1'b0; preload = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      subword = v.we && !v.size[1];
      ok = (v.exp_code == 2'b00);
      @(negedge clk);
      req_valid = 1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
      #1;
      chk($sformatf("v%0d mem_read", i), mem_read, ok && (!v.we || subword));
      chk($sformatf("v%0d mem_write", i), mem_write, ok && v.we && !subword);
      chk($sformatf("v%0d stall", i), stall, 0);
      if (ok) chk($sformatf("v%0d mem_addr", i), mem_addr, v.addr >> 2);
      if (ok && v.we && !subword) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d resp_valid", i), resp_valid, v.exp_valid);
      if (v.exp_valid) begin
        chk($sformatf("v%0d resp_data", i), resp_data, v.exp_data);
        chk($sformatf("v%0d resp_rd", i), resp_rd, v.rd);
      end
      chk($sformatf("v%0d fault", i), fault, !ok);
      if (!ok) begin
        chk($sformatf("v%0d fault_code", i), fault_code, v.exp_code);
        chk($sformatf("v%0d fault_addr", i), fault_addr, v.addr);
      end
      if (ok && subword) begin
        chk($sformatf("v%0d write stall", i), stall, 1);
        chk($sformatf("v%0d write mem_write", i), mem_write, 1);
        chk($sformatf("v%0d write mem_read", i), mem_read, 0);
        chk($sformatf("v%0d write mem_addr", i), mem_addr, v.addr >> 2);
        chk($sformatf("v%0d write mem_wdata", i), mem_wdata, v.exp_wdata);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d post-write stall", i), stall, 0);
      end
    end
    @(negedge clk);
    req_valid = 0;

    // Reset during WRITE drops the pending half store to word 7.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b01; req_addr = 32'h1E; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    req_valid = 0;
    chk("rstwr stall before", stall, 1);
    chk("rstwr mem_write before", mem_write, 1);
    rst = 1'b1;
    #1;
    chk("rstwr mem_write", mem_write, 0);
    chk("rstwr stall", stall, 0);
    chk("rstwr mem_read", mem_read, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstwr word7", mem[7], 32'h7);
    chk("rstwr resp_valid", resp_valid, 0);
    chk("rstwr resp_data", resp_data, 0);
    chk("rstwr resp_rd", resp_rd, 0);
    chk("rstwr fault", fault, 0);
    chk("rstwr fault_code", fault_code, 0);
    chk("rstwr fault_addr", fault_addr, 0);

    // Reset during a load's accept cycle suppresses resp_valid.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h14; req_rd = 5'd12;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 0;
    chk("rstld resp_valid", resp_valid, 0);
    @(posedge clk);
    #1;
    chk("rstld resp_valid later", resp_valid, 0);

    // Alternating load / word-store stream, one request per cycle.
    pulses = 0;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1; req_size = 2'b10; req_signed = 0;
      if (i % 2 == 0) begin
        req_we = 0; req_addr = 4 * (19 + i); req_rd = 5'(i);
      end else begin
        req_we = 1; req_addr = 4 * (20 + i); req_wdata = 32'hC0DE0000 + i;
      end
      #1;
      if (stall) stalls++;
      @(posedge clk);
      #1;
      if (resp_valid) pulses++;
      if (i % 2 == 0) begin
        chk($sformatf("s%0d resp_valid", i), resp_valid, 1);
        chk($sformatf("s%0d resp_data", i), resp_data,
            (i == 0) ? 32'd19 : 32'hC0DE0000 + i - 1);
        chk($sformatf("s%0d resp_rd", i), resp_rd, i);
      end else begin
        chk($sformatf("s%0d resp_valid", i), resp_valid, 0);
      end
    end
    @(negedge clk);
    req_valid = 0;
    chk("stream pulses", pulses, 4);
    chk("stream stalls", stalls, 0);
    chk("stream word27", mem[27], 32'hC0DE0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the word-addressed data memory. Accepts one load or store per cycle with byte/half/word size, checks alignment and range, and performs little-endian lane extraction with sign/zero extension on loads. Sub-word stores become a two-cycle read-modify-write, with a pipeline stall in the second cycle. Registered load results and faults go to the MEM/WB register.

## Interface
- ADDR_W, 5, data memory word-index width (2^ADDR_W words)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present (ignored while stall=1)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_rd  in  5  load destination register
- stall  out  1  upstream must hold its request this cycle
- mem_addr  out  32  word index to memory (upper bits zero)
- mem_wdata  out  32  word write data
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_rdata  in  32  combinational memory read data
- resp_valid  out  1  load result valid (1-cycle pulse)
- resp_data  out  32  extended load result
- resp_rd  out  5  destination register of resp_data
- fault  out  1  access fault (1-cycle pulse)
- fault_code  out  2  01 misaligned, 10 out of range
- fault_addr  out  32  byte address of the faulting request

## Operation
- States are IDLE and WRITE. A request is accepted when req_valid=1 in IDLE.
- Misalignment check: half with addr[0]=1, or word with addr[1:0]≠0.
- Range check: req_addr[31:ADDR_W+2] ≠ 0.
- Misalignment takes priority over range.
- A faulting request makes no memory access and produces no resp_valid.
- On a fault, the next cycle has fault=1 with fault_code and fault_addr; all three are registered.
- Word index = req_addr[ADDR_W+1:2]. Byte lane = addr[1:0]. Half lane = addr[1] (bits 15:0 or 31:16).
- Load, accept cycle:
  - Drive mem_read=1 and mem_addr; sample mem_rdata.
  - Select the lane and extend: byte uses bit 7, half uses bit 15 when req_signed=1.
  - Register the result into resp_data/resp_rd with resp_valid=1.
  - State stays IDLE.
- Word store, accept cycle: drive mem_write=1, mem_addr, mem_wdata=req_wdata. State stays IDLE.
- Byte/half store:
  - Accept cycle: drive mem_read=1, sample mem_rdata, replace the target lane(s) with req_wdata[7:0] or [15:0], and latch the merged word and index. Next state is WRITE.
  - WRITE cycle: mem_write=1, mem_addr/mem_wdata from the latched registers, stall=1, mem_read=0. Next state is IDLE.
- stall = (state==WRITE), driven combinationally from the state register.
- Memory-side outputs are combinational from the request (IDLE) or the latched registers (WRITE). All are 0 when there is no access.
- A load to req_rd=0 still produces resp_valid; the register file discards it.

## Timing
- Reset values:
  - state IDLE.
  - stall, mem_write, mem_read = 0.
  - resp_valid, resp_data, resp_rd, fault, fault_code, fault_addr = 0.
- Load latency: resp_valid rises at the edge after acceptance, for exactly 1 cycle.
- Word store: 1 cycle, no stall.
- Byte/half store: 2 cycles, with stall high in the second.
- Back-to-back:
  - Loads and word stores can be accepted every cycle.
  - After a sub-word store, the next request is accepted in the cycle after WRITE.
  - A load to the same word sees the merged data.
- Reset asserted in WRITE: immediately return to IDLE with mem_write=0 and stall=0. The pending write is dropped.
- Reset asserted in a load's accept cycle: no resp_valid is produced.
- Back-to-back faults give consecutive fault pulses, each carrying its own fault_addr.

## Test plan
- Reset, memory preloaded data[i]=i; word load addr 0x14 -> next cycle resp_valid=1, resp_data=5, resp_rd=req_rd.
- Word store 0xDEADBEEF @0x08, then signed byte load @0x0B -> resp_data=0xFFFFFFDE. Unsigned half load @0x08 -> 0x0000BEEF.
- Byte store 0xAA @0x11 (word 4 = 4) -> stall=1 for one cycle, mem_wdata=0x0000AA04. A following word load @0x10 returns 0x0000AA04.
- Half load @0x03 -> fault=1, fault_code=01, fault_addr=0x03, no resp_valid, mem_read=0. Word load @0x80 -> fault_code=10.
- Half store @0x1E, then assert rst during WRITE -> mem_write drops immediately, word 7 keeps 7, all outputs return to 0.
- Alternating load/word-store stream of 8 requests -> no stall, 4 resp_valid pulses with correct data.
